// File: rtl/tinymemif_arbiter_if.sv
// tinymemif: single-requester memory port. The master issues rd/wr requests;
// the slave answers with busy (high until completion) and rd_data.
interface tinymemif;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;

    logic              rd_enable;
    logic              wr_enable;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_enable, wr_enable, addr, size, wr_data,
                    input  busy, rd_data);
    modport slave  (input  rd_enable, wr_enable, addr, size, wr_data,
                    output busy, rd_data);
endinterface

// File: rtl/tinymemif_arbiter.sv
// Two-port tinymemif arbiter: fetch (port 0) and data (port 1) share one memory port.
// Define TINYMEMIF_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to port 0.
module tinymemif_arbiter (
    input  logic     clk_i,
    input  logic     reset_n_i,
    tinymemif.slave  memif_if,
    tinymemif.slave  memif_dt,
    tinymemif.master memif_mem,
    output logic     owner_o,
    output logic     active_o
);
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_pend;
    logic [1:0]        r_kind_rd;
    logic [ADDR_W-1:0] r_addr  [2];
    logic [SIZE_W-1:0] r_size  [2];
    logic [DATA_W-1:0] r_wdata [2];
    logic [DATA_W-1:0] r_rd_data_q;
    logic              r_owner;

    logic [1:0]        w_en;
    logic [1:0]        w_rd;
    logic [1:0]        w_cap;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [SIZE_W-1:0] w_size  [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic              w_win;
    logic              w_grant;
    logic              w_done;
    logic              w_load;
    logic              w_active;

    // Read wins when a requester raises both enables.
    assign w_en       = {memif_dt.rd_enable | memif_dt.wr_enable,
                         memif_if.rd_enable | memif_if.wr_enable};
    assign w_rd       = {memif_dt.rd_enable, memif_if.rd_enable};
    assign w_addr[0]  = memif_if.addr;
    assign w_addr[1]  = memif_dt.addr;
    assign w_size[0]  = memif_if.size;
    assign w_size[1]  = memif_dt.size;
    assign w_wdata[0] = memif_if.wr_data;
    assign w_wdata[1] = memif_dt.wr_data;

    assign w_cap    = w_en & ~r_pend;
    assign w_grant  = (r_state == IDLE) && (r_pend != 2'b00);
    assign w_done   = (r_state == WAIT_DONE) && !memif_mem.busy;
    assign w_load   = ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE)) && memif_mem.busy;
    assign w_active = (r_state != IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pend <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (w_cap[k])
                    r_pend[k] <= 1'b1;
                else if (w_done && (int'(r_owner) == k))
                    r_pend[k] <= 1'b0;
            end
        end
    end

    // Request payload only matters once pend is set, so it carries no reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (w_cap[k]) begin
                r_kind_rd[k] <= w_rd[k];
                r_addr[k]    <= w_addr[k];
                r_size[k]    <= w_size[k];
                r_wdata[k]   <= w_wdata[k];
            end
        end
    end

`ifdef TINYMEMIF_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_last_grant <= 1'b1;
        else if (w_grant)
            r_last_grant <= w_win;
    end

    assign w_win = (&r_pend) ? ~r_last_grant : r_pend[1];
`else
    assign w_win = ~r_pend[0];
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_rd_data_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant)
                r_owner <= w_win;
            if (w_load)
                r_rd_data_q <= memif_mem.rd_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_grant)         w_state_nxt = ISSUE;
            ISSUE:     if (!memif_mem.busy) w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (memif_mem.busy)  w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (!memif_mem.busy) w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    assign memif_mem.rd_enable = (r_state == ISSUE) &&  r_kind_rd[r_owner];
    assign memif_mem.wr_enable = (r_state == ISSUE) && !r_kind_rd[r_owner];
    assign memif_mem.addr      = w_active ? r_addr[r_owner]  : '0;
    assign memif_mem.size      = w_active ? r_size[r_owner]  : '0;
    assign memif_mem.wr_data   = w_active ? r_wdata[r_owner] : '0;

    assign memif_if.busy    = r_pend[0];
    assign memif_dt.busy    = r_pend[1];
    assign memif_if.rd_data = r_rd_data_q;
    assign memif_dt.rd_data = r_rd_data_q;

    assign owner_o  = r_owner;
    assign active_o = w_active;
endmodule

// File: tb/tb_tinymemif_arbiter.sv
// Bench for tinymemif_arbiter: transaction-level model of the two ports plus a
// behavioural downstream memory, with directed scenarios and literal expectations.
module tb_tinymemif_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tinymemif u_if0 ();
    tinymemif u_if1 ();
    tinymemif u_mem ();
    logic owner, active;

    tinymemif_arbiter dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .memif_if  (u_if0),
        .memif_dt  (u_if1),
        .memif_mem (u_mem),
        .owner_o   (owner),
        .active_o  (active)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int glog[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
    endfunction

    // Downstream memory: accepts when idle, raises busy next cycle for mem_b cycles.
    int          mem_b = 2;
    logic        stall_busy = 1'b0;
    int          cnt;
    logic [31:0] tx_data;
    int          rd_cyc = 0;
    int          wr_cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 0;
            tx_data <= 32'h0;
        end else begin
            if (u_mem.rd_enable) rd_cyc <= rd_cyc + 1;
            if (u_mem.wr_enable) wr_cyc <= wr_cyc + 1;
            if (cnt != 0)
                cnt <= cnt - 1;
            else if ((u_mem.rd_enable || u_mem.wr_enable) && !stall_busy) begin
                cnt     <= mem_b;
                tx_data <= fdata(u_mem.addr);
            end
        end
    end
    assign u_mem.busy    = (cnt != 0) || stall_busy;
    assign u_mem.rd_data = (cnt != 0) ? tx_data : 32'h0;

    // Transaction-level model of the arbiter.
    logic [1:0]  m_pend;
    logic        m_tx, m_acc, m_seen, m_own, m_last, m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rd   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wd   [2];
    logic [1:0]  m_size [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 2'b00; m_tx <= 1'b0; m_acc <= 1'b0; m_seen <= 1'b0;
            m_own <= 1'b0; m_last <= 1'b1; m_rvalid <= 1'b1; m_rdata <= 32'h0;
        end else begin
            logic [1:0] p;
            logic       w;
            p = m_pend;
            if ((u_if0.rd_enable || u_if0.wr_enable) && !m_pend[0]) begin
                p[0] = 1'b1;
                m_rd[0] <= u_if0.rd_enable; m_addr[0] <= u_if0.addr;
                m_size[0] <= u_if0.size;    m_wd[0] <= u_if0.wr_data;
            end
            if ((u_if1.rd_enable || u_if1.wr_enable) && !m_pend[1]) begin
                p[1] = 1'b1;
                m_rd[1] <= u_if1.rd_enable; m_addr[1] <= u_if1.addr;
                m_size[1] <= u_if1.size;    m_wd[1] <= u_if1.wr_data;
            end
            if (m_tx && m_acc && m_seen && !u_mem.busy) begin
                p[m_own] = 1'b0;
                m_tx <= 1'b0; m_rdata <= tx_data; m_rvalid <= 1'b1;
            end else if (m_tx && m_acc && u_mem.busy) begin
                m_seen <= 1'b1;
            end else if (m_tx && !m_acc && (u_mem.rd_enable || u_mem.wr_enable) && !u_mem.busy) begin
                m_acc <= 1'b1; m_rvalid <= 1'b0;
            end else if (!m_tx && (m_pend != 2'b00)) begin
                if (m_pend[0] && m_pend[1]) begin
`ifdef TINYMEMIF_ARB_RR_EN
                    w = (m_last == 1'b0) ? 1'b1 : 1'b0;
`else
                    w = 1'b0;
`endif
                end else begin
                    w = m_pend[1] ? 1'b1 : 1'b0;
                end
                m_tx <= 1'b1; m_acc <= 1'b0; m_seen <= 1'b0; m_own <= w; m_last <= w;
            end
            m_pend <= p;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy0", u_if0.busy, 0);
            chk("rst_busy1", u_if1.busy, 0);
            chk("rst_en", {u_mem.rd_enable, u_mem.wr_enable}, 0);
            chk("rst_addr", u_mem.addr, 0);
            chk("rst_owner", owner, 0);
            chk("rst_active", active, 0);
            chk("rst_rdata", u_if0.rd_data, 0);
        end else begin
            chk("busy0", u_if0.busy, m_pend[0]);
            chk("busy1", u_if1.busy, m_pend[1]);
            chk("active", active, m_tx);
            if (!m_tx) chk("addr_idle", u_mem.addr, 0);
            if ((u_mem.rd_enable || u_mem.wr_enable) && !(m_tx && !m_acc))
                chk("en_outside_issue", {u_mem.rd_enable, u_mem.wr_enable}, 0);
            if (m_rvalid) begin
                chk("rdata0", u_if0.rd_data, m_rdata);
                chk("rdata1", u_if1.rd_data, m_rdata);
            end
            if (m_tx && !m_acc && (u_mem.rd_enable || u_mem.wr_enable) && !u_mem.busy) begin
                chk("grant_owner", owner, m_own);
                chk("grant_addr", u_mem.addr, m_addr[m_own]);
                chk("grant_size", u_mem.size, m_size[m_own]);
                chk("grant_rd", u_mem.rd_enable, m_rd[m_own]);
                chk("grant_wr", u_mem.wr_enable, !m_rd[m_own]);
                if (!m_rd[m_own]) chk("grant_wdata", u_mem.wr_data, m_wd[m_own]);
                glog.push_back(int'(owner));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [1:0] s, input logic [31:0] d);
        if (k == 0) begin
            u_if0.rd_enable = rd; u_if0.wr_enable = wr; u_if0.addr = a; u_if0.size = s; u_if0.wr_data = d;
        end else begin
            u_if1.rd_enable = rd; u_if1.wr_enable = wr; u_if1.addr = a; u_if1.size = s; u_if1.wr_data = d;
        end
    endtask

    task automatic clr_req(input int k);
        if (k == 0) begin u_if0.rd_enable = 1'b0; u_if0.wr_enable = 1'b0; end
        else        begin u_if1.rd_enable = 1'b0; u_if1.wr_enable = 1'b0; end
    endtask

    task automatic wait_quiet(input int maxc);
        int n = 0;
        while ((u_if0.busy || u_if1.busy || active) && n < maxc) begin
            tick();
            n++;
        end
        if (n >= maxc) begin
            checks++; errors++;
            $display("FAIL wait_quiet timeout: still busy after %0d cycles, required idle", maxc);
        end
        tick();
    endtask

    task automatic chk_log(input string nm, input int n, input logic [7:0] pat);
        chk({nm, "_len"}, glog.size(), n);
        for (int i = 0; i < n; i++)
            chk(nm, (i < glog.size()) ? glog[i] : 32'hFFFF_FFFF, {31'b0, pat[i]});
    endtask

    task automatic pair(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d1);
        set_req(0, 1, 0, a0, 2'b10, 32'h0);
        set_req(1, 0, 1, a1, 2'b01, d1);
        tick();
        clr_req(0); clr_req(1);
        wait_quiet(60);
    endtask

    initial begin
        int r0, w0, n;
        clr_req(0); clr_req(1);
        set_req(0, 0, 0, 32'h0, 2'b00, 32'h0);
        set_req(1, 0, 0, 32'h0, 2'b00, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_quiet(10);

        // Single read on port 0, B = 2; cycle n relative to the request cycle.
        r0 = rd_cyc;
        set_req(0, 1, 0, 32'h100, 2'b10, 32'h0);
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            chk("t1_busy", u_if0.busy, (i >= 1 && i <= 5));
            if (i == 1) chk("t1_idle_active", active, 0);
            if (i == 2) begin
                chk("t1_issue_rd", u_mem.rd_enable, 1);
                chk("t1_issue_addr", u_mem.addr, 32'h100);
                chk("t1_issue_active", active, 1);
            end
            if (i == 6) chk("t1_rdata", u_if0.rd_data, 32'hDEADBEEF);
            tick();
            if (i == 0) clr_req(0);
        end
        wait_quiet(20);
        chk("t1_rd_cycles", rd_cyc - r0, 1);

        // Simultaneous requests, then two more pairs.
        glog.delete();
        pair(32'h10, 32'h20, 32'h55);
        chk_log("t2_first", 2, 8'b10);
        pair(32'h14, 32'h24, 32'h66);
        pair(32'h18, 32'h28, 32'h77);
        chk_log("t2_pairs", 6, 8'b101010);

        // Sole port-0 grant followed by a tie separates the two priority modes.
        glog.delete();
        set_req(0, 1, 0, 32'h30, 2'b10, 32'h0);
        tick(); clr_req(0);
        wait_quiet(30);
        pair(32'h34, 32'h38, 32'h99);
`ifdef TINYMEMIF_ARB_RR_EN
        chk_log("t2_tie", 3, 8'b010);
`else
        chk_log("t2_tie", 3, 8'b100);
`endif

        // Port 1 re-requests in its completion cycle while port 0 is pending.
        glog.delete();
        set_req(1, 1, 0, 32'h300, 2'b10, 32'h0);
        tick(); clr_req(1);
        tick();
        set_req(0, 1, 0, 32'h200, 2'b10, 32'h0);
        tick(); clr_req(0);
        n = 0;
        while (u_if1.busy && n < 40) begin tick(); n++; end
        chk("t3_p1_done", u_if1.busy, 0);
        set_req(1, 0, 1, 32'h304, 2'b10, 32'h1234);
        tick(); clr_req(1);
        chk("t3_pend1_next", u_if1.busy, 1);
        wait_quiet(60);
        chk_log("t3_order", 3, 8'b101);

        // Both enables high on port 1.
        r0 = rd_cyc; w0 = wr_cyc;
        set_req(1, 1, 1, 32'h400, 2'b10, 32'hAAAA);
        tick(); clr_req(1);
        wait_quiet(30);
        chk("t4_rd_cycles", rd_cyc - r0, 1);
        chk("t4_wr_cycles", wr_cyc - w0, 0);

        // Downstream busy high for 3 cycles at ISSUE entry.
        r0 = rd_cyc;
        set_req(0, 1, 0, 32'h500, 2'b10, 32'h0);
        tick(); clr_req(0); stall_busy = 1'b1;
        tick(); tick(); tick();
        tick(); stall_busy = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_wb_en", u_mem.rd_enable, 0);
        chk("t5_wb_active", active, 1);
        chk("t5_wb_busy", u_mem.busy, 1);
        wait_quiet(30);
        chk("t5_en_cycles", rd_cyc - r0, 4);

        // Reset during WAIT_DONE of a port-1 read, then a normal port-0 read.
        mem_b = 4;
        set_req(1, 1, 0, 32'h600, 2'b10, 32'h0);
        tick(); clr_req(1);
        repeat (4) tick();
        chk("t6_pre_owner", owner, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_en", u_mem.rd_enable, 0);
        chk("t6_rst_busy1", u_if1.busy, 0);
        chk("t6_rst_active", active, 0);
        chk("t6_rst_owner", owner, 0);
        chk("t6_rst_addr", u_mem.addr, 0);
        chk("t6_rst_rdata", u_if1.rd_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mem_b = 2;
        glog.delete();
        set_req(0, 1, 0, 32'h700, 2'b10, 32'h0);
        tick(); clr_req(0);
        wait_quiet(30);
        chk_log("t6_after", 1, 8'b0);
        chk("t6_rdata", u_if0.rd_data, 32'h0700C0DE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tinymemif_arbiter.md
# tinymemif_arbiter

Two-port arbiter that shares the single `tinymemif` memory port between instruction fetch (port 0) and data access (port 1). Sits between the core's fetch/LSU units and the TileLink memory controller master. Each requester's request is latched, one owner is granted at a time, and the latched request is replayed downstream. Completion and read data are returned to the owner.

## Interface
Parameters:
- None. All address, data and size widths are taken from `tinymemif`.

Ports:
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `memif_if`  `tinymemif.slave`  —  port 0, instruction fetch.
- `memif_dt`  `tinymemif.slave`  —  port 1, data access.
- `memif_mem`  `tinymemif.master`  —  downstream port to the memory controller.
- `owner_o`  out  1  index of the current or last granted port.
- `active_o`  out  1  high whenever state ≠ IDLE.

## Operation
- **Protocol (both sides):**
  - A request is `rd_enable` or `wr_enable` sampled high while that side's `busy` is 0.
  - `busy` goes high the next cycle and stays high until completion.
  - Completion is the first cycle `busy` is low again.
  - The requester drops its enable once it sees `busy` = 1.
  - If `rd_enable` and `wr_enable` are both high, the request is a read.
- **Capture, per port k:**
  - When `en_k && !pend_k`, latch kind (rd/wr), address, size and write data, and set `pend_k`.
  - Upstream `busy_k = pend_k`, registered.
  - An enable raised while `pend_k` = 1 is ignored.
- **FSM states:**
  - IDLE: if any `pend` is set, pick the owner per priority, set `owner_o`, go to ISSUE.
  - ISSUE: drive the owner's latched request downstream with the enable high. If downstream `busy` = 0 this cycle, go to WAIT_BUSY; otherwise stay in ISSUE.
  - WAIT_BUSY: when downstream `busy` = 1, go to WAIT_DONE. In that same cycle, load `rd_data` into `rd_data_q`.
  - WAIT_DONE: while downstream `busy` = 1, load `rd_data` into `rd_data_q`. When `busy` = 0, clear `pend_owner` and go to IDLE.
- **Downstream outputs:**
  - `rd_enable`/`wr_enable` are high only in ISSUE, selected by the latched kind.
  - Address, size and write data come from the owner's latch in every state; they are 0 in IDLE.
- **Upstream read data:** both ports see `rd_data = rd_data_q`. It is held stable from the owner's completion cycle until the next WAIT_BUSY.
- **Priority on simultaneous pends:** set by `TINYMEMIF_ARB_RR_EN` (see Configuration). A single pend is always granted regardless of mode.

## Timing
- **Reset values:** all `pend` = 0, state IDLE, downstream enables 0, downstream address/size/data 0, upstream `busy` 0, `rd_data_q` 0, `owner_o` 0, `active_o` 0, `last_grant` 1.
- **Reference latency:** with a downstream that raises `busy` one cycle after accept and holds it for B cycles:
  - Request seen in cycle 0.
  - `busy_k` = 1 from cycle 1.
  - ISSUE in cycle 2.
  - WAIT_BUSY in cycle 3.
  - WAIT_DONE in cycle 4.
  - `busy_k` = 0 in cycle 4 + B − 1 + 1.
  - For B = 2: `busy_k` = 0 in cycle 6.
- **Back-to-back requests:** port k can re-request in its completion cycle (`busy_k` = 0). The capture lands the next cycle. The FSM has a minimum of one IDLE cycle between grants.
- **Both ports request in the same cycle:** both are latched. Two serialized transactions follow, ordered by priority.
- **Reset asserted mid-transaction:**
  - Everything clears immediately and asynchronously.
  - The downstream enable drops the same instant.
  - The downstream controller must itself be reset together with this block.
- **ISSUE stall:** ISSUE holds the enable for as many cycles as downstream `busy` stays high at entry.

## Configuration
- `TINYMEMIF_ARB_RR_EN` defined:
  - Round-robin priority: the port not equal to `last_grant` wins a tie.
  - `last_grant` updates on IDLE→ISSUE.
- Not defined:
  - Fixed priority: port 0 (fetch) always wins a tie.
  - `last_grant` is not implemented.

## Test plan
- **Single read on port 0:** addr 0x100, word size; downstream returns 0xDEADBEEF after B = 2 → `memif_if.busy` high in cycles 1–5, low in cycle 6; `rd_data` = 0xDEADBEEF; exactly one downstream `rd_enable` cycle.
- **Simultaneous requests:** port 0 read 0x10 and port 1 write 0x20 data 0x55 in the same cycle →
  - Macro off: the read issues first, then the write.
  - Macro on: two more simultaneous pairs alternate port 0, 1, 0, 1.
- **Port 1 re-requests in its completion cycle** while port 0 is pending → port 0 is granted next, in both modes. `pend_1` sets one cycle after the enable.
- **Both enables high on port 1** → a downstream read is issued and `wr_enable` stays 0.
- **Downstream `busy` held high for 3 cycles at ISSUE entry** → the enable is held 4 cycles, then one WAIT_BUSY cycle follows.
- **Reset in WAIT_DONE** → all outputs take their reset values within the same cycle. After release, a new port 0 request completes normally.
